// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   sas_state_t   : sequencer FSM states (IDLE, RUN, DONE)
//   SAS_MAX_WIDTH : largest supported operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sas_state_t;

  localparam int SAS_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_seq_adder.sv
// 1-bit full-adder cell.
// Ports:
//   a, b  in  1  addend bits
//   c_in  in  1  carry in
//   o     out 1  sum bit
//   c_out out 1  carry out
module adder (
  output logic o,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign o     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first
// through a single full-adder cell, one bit per clock, collecting the
// sum bits in a result shift register.
// Ports:
//   clk   in  1      rising-edge clock
//   rst_n in  1      asynchronous active-low reset
//   start in  1      request; sampled only in IDLE or DONE
//   a, b  in  WIDTH  operands, captured on an accepted start
//   c_in  in  1      initial carry, captured on an accepted start
//   busy  out 1      high while the add is in progress (state RUN)
//   done  out 1      one-cycle pulse when the result is ready (state DONE)
//   sum   out WIDTH  result, valid while done is high
//   c_out out 1      final carry, valid while done is high
//
// Handshake: start is a level request with no back-pressure. It is
// accepted on any rising edge where the sequencer is in IDLE or DONE and
// ignored while busy. Each accepted start yields exactly one done pulse
// WIDTH+1 cycles later, unless reset intervenes. Holding start through
// the DONE cycle launches the next add back-to-back.
// WIDTH must lie in 2..SAS_MAX_WIDTH.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sas_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_o;
  logic fa_c;

  adder u_fa (
    .o    (fa_o),
    .c_out(fa_c),
    .a    (sa[0]),
    .b    (sb[0]),
    .c_in (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE with no new request drops back to IDLE; sr and carry
          // are untouched so the result stays visible.
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            carry <= c_in;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Sum bits enter at the top so the first bit computed lands in sr[0].
          sr    <= {fa_o, sr[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_c;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sr and carry hold the finished result until the next accepted start.
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign sum   = sr;
  assign c_out = carry;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start2, start8, start32;
  logic [1:0]  a2, b2;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        c_in2, c_in8, c_in32;
  logic        busy2, busy8, busy32;
  logic        done2, done8, done32;
  logic [1:0]  sum2;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic        c_out2, c_out8, c_out32;

  serial_add_seq #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2)
  );
  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(c_in8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8)
  );
  serial_add_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .c_in(c_in32),
    .busy(busy32), .done(done32), .sum(sum32), .c_out(c_out32)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [2:0]  exp2_q[$];
  logic [8:0]  exp8_q[$];
  logic [32:0] exp32_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop one expected {c_out,sum} per done cycle.
  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (exp2_q.size() == 0) chk("w2_unexpected_done", 64'd1, 64'd0);
      else chk("w2_result", 64'({c_out2, sum2}), 64'(exp2_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (exp8_q.size() == 0) chk("w8_unexpected_done", 64'd1, 64'd0);
      else chk("w8_result", 64'({c_out8, sum8}), 64'(exp8_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (exp32_q.size() == 0) chk("w32_unexpected_done", 64'd1, 64'd0);
      else chk("w32_result", 64'({c_out32, sum32}), 64'(exp32_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // Counts cycles after the accepting edge until done, checking latency
  // WIDTH+1, WIDTH busy cycles, and busy low in the done cycle.
  task automatic wait_done(input int which, input int width);
    int lat = 0;
    int bcnt = 0;
    logic d, bz;
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(negedge clk);
      case (which)
        2:  begin d = done2;  bz = busy2;  end
        8:  begin d = done8;  bz = busy8;  end
        default: begin d = done32; bz = busy32; end
      endcase
      if (d) begin
        lat = i;
        chk($sformatf("w%0d_busy_in_done", width), 64'(bz), 64'd0);
      end else if (bz) begin
        bcnt++;
      end
    end
    chk($sformatf("w%0d_latency", width), 64'(lat), 64'(width + 1));
    chk($sformatf("w%0d_busy_cycles", width), 64'(bcnt), 64'(width));
  endtask

  // Issues one start at a negedge, drops start after the accepting edge.
  task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [32:0] req);
    case (which)
      2: begin a2 = a[1:0]; b2 = b[1:0]; c_in2 = c; start2 = 1'b1; exp2_q.push_back(req[2:0]); end
      8: begin a8 = a[7:0]; b8 = b[7:0]; c_in8 = c; start8 = 1'b1; exp8_q.push_back(req[8:0]); end
      default: begin a32 = a; b32 = b; c_in32 = c; start32 = 1'b1; exp32_q.push_back(req); end
    endcase
    @(posedge clk);
    #1;
    start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
    case (which)
      2: wait_done(2, 2);
      8: wait_done(8, 8);
      default: wait_done(32, 32);
    endcase
    @(negedge clk);
  endtask

  // ---------------- directed vectors (hand-computed results) ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [32:0] r;
  } vec_t;

  vec_t v8[7] = '{
    '{32'h3C, 32'h05, 1'b0, 33'h041},
    '{32'hFF, 32'h01, 1'b0, 33'h100},
    '{32'h00, 32'h00, 1'b1, 33'h001},
    '{32'hFF, 32'hFF, 1'b1, 33'h1FF},
    '{32'h00, 32'h00, 1'b0, 33'h000},
    '{32'hA5, 32'h5A, 1'b0, 33'h0FF},
    '{32'h7F, 32'h01, 1'b1, 33'h081}
  };
  vec_t v2[4] = '{
    '{32'h3, 32'h3, 1'b1, 33'h7},
    '{32'h0, 32'h0, 1'b0, 33'h0},
    '{32'h2, 32'h1, 1'b0, 33'h3},
    '{32'h3, 32'h0, 1'b1, 33'h4}
  };
  vec_t v32[6] = '{
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF},
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000},
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000},
    '{32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000},
    '{32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 33'h0_DEAD_BEF0}
  };

  // ---------------- main sequence ----------------
  initial begin
    int dcount;
    start2 = 0; start8 = 0; start32 = 0;
    a2 = '0; b2 = '0; c_in2 = 0;
    a8 = '0; b8 = '0; c_in8 = 0;
    a32 = '0; b32 = '0; c_in32 = 0;

    repeat (3) @(negedge clk);
    chk("reset_w8_outputs", 64'({busy8, done8, c_out8, sum8}), 64'd0);
    chk("reset_w32_outputs", 64'({busy32, done32, c_out32, sum32}), 64'd0);
    chk("reset_w2_outputs", 64'({busy2, done2, c_out2, sum2}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (v8[i]) issue(8, v8[i].a, v8[i].b, v8[i].c, v8[i].r);
    foreach (v2[i]) issue(2, v2[i].a, v2[i].b, v2[i].c, v2[i].r);
    foreach (v32[i]) issue(32, v32[i].a, v32[i].b, v32[i].c, v32[i].r);

    // start held through RUN with operands changed mid-flight; 10+20 must
    // be unaffected, then a start seen in the DONE cycle launches 80+80.
    a8 = 8'h10; b8 = 8'h20; c_in8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back(9'h030);
    @(posedge clk);
    #1;
    a8 = 8'hAA; b8 = 8'h55; c_in8 = 1'b1;
    wait_done(8, 8);
    a8 = 8'h80; b8 = 8'h80; c_in8 = 1'b0;
    exp8_q.push_back(9'h100);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done(8, 8);
    @(negedge clk);

    // Reset in the 4th RUN cycle: outputs clear at once, no done follows.
    a8 = 8'h12; b8 = 8'h34; c_in8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 64'({busy8, done8, c_out8, sum8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dcount++;
    end
    chk("no_done_after_reset", 64'(dcount), 64'd0);
    issue(8, 32'h3C, 32'h05, 1'b0, 33'h041);

    repeat (3) @(negedge clk);
    chk("w2_queue_empty", 64'(exp2_q.size()), 64'd0);
    chk("w8_queue_empty", 64'(exp8_q.size()), 64'd0);
    chk("w32_queue_empty", 64'(exp32_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
